clk_div_gen: RTL and testbench



---
 rtl/clk_div_gen.sv | 126 ++++++++++++
 tb/tb_clk_div_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable divider producing clk_out and a rise strobe
// from clk_in. Ratio changes via div_load/load_ack, applied at period wrap.
// Ports: clk_in, rst (sync, active-high), en, div_ratio, div_load,
//        load_ack, clk_out, tick, busy [, period_cnt].
// Optional: define CLKDIV_STATUS_EN to add the period_cnt status output.
module clk_div_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
`ifdef CLKDIV_STATUS_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act;
  logic [DIV_W-1:0] pend;
  logic             pend_v;

  logic [DIV_W-1:0] ld_val;
  logic [DIV_W:0]   high_t;
  logic [DIV_W:0]   cnt_inc;
  logic             wrap;

  // Ratios 0 and 1 cannot form a two-phase clock; store them as 2.
  assign ld_val  = (div_ratio < DIV_W'(2)) ? DIV_W'(2) : div_ratio;
  // ceil(N/2) with one spare bit so N = 2^DIV_W-1 cannot overflow.
  assign high_t  = ({1'b0, act} + 1'b1) >> 1;
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign wrap    = (cnt == act - 1'b1);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      act      <= DIV_W'(DEFAULT_DIV);
      pend     <= '0;
      pend_v   <= 1'b0;
      load_ack <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      load_ack <= div_load;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // No period in flight: a load takes effect at once.
          if (div_load) begin
            act    <= ld_val;
            pend_v <= 1'b0;
          end else if (pend_v) begin
            act    <= pend;
            pend_v <= 1'b0;
          end
          if (en) begin
            state   <= RUN;
            clk_out <= 1'b1;
            tick    <= 1'b1;
            busy    <= 1'b1;
          end else begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          if (div_load) begin
            pend   <= ld_val;
            pend_v <= 1'b1;
          end
          if (wrap) begin
            cnt <= '0;
            // The older pending value is applied here; a load on
            // this same edge waits for the next boundary.
            if (pend_v) act <= pend;
            if (pend_v && !div_load) pend_v <= 1'b0;
            if (en) begin
              clk_out <= 1'b1;
              tick    <= 1'b1;
            end else begin
              state   <= IDLE;
              clk_out <= 1'b0;
              tick    <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            cnt     <= cnt_inc[DIV_W-1:0];
            clk_out <= (cnt_inc < high_t);
            tick    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CLKDIV_STATUS_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (state == RUN && wrap) begin
      if (period_cnt != 16'hFFFF)
        period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: vector table + scoreboard bench for clk_div_gen.
// Each vector's expected post-edge outputs are queued and checked later.
module tb_clk_div_gen;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_ratio;
  logic       div_load;
  logic       load_ack;
  logic       clk_out;
  logic       tick;
  logic       busy;
`ifdef CLKDIV_STATUS_EN
  logic [15:0] period_cnt;
`endif

  clk_div_gen #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_ratio (div_ratio),
    .div_load  (div_load),
    .load_ack  (load_ack),
    .clk_out   (clk_out),
    .tick      (tick),
`ifdef CLKDIV_STATUS_EN
    .period_cnt(period_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit       r;
    bit       e;
    bit       l;
    bit [7:0] d;
    bit       c;
    bit       t;
    bit       b;
    bit       a;
  } vec_t;

  typedef struct {
    int        idx;
    bit        c;
    bit        t;
    bit        b;
    bit        a;
    bit [15:0] pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(bit r, bit e, bit l, bit [7:0] d,
                              bit c, bit t, bit b, bit a);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.d = d;
    v.c = c; v.t = t; v.b = b; v.a = a;
    vecs.push_back(v);
  endfunction

  task automatic check_one();
    exp_t x;
    bit   bad;
    x = sb.pop_front();
    checks++;
    bad = (clk_out !== x.c) || (tick !== x.t) ||
          (busy !== x.b) || (load_ack !== x.a);
`ifdef CLKDIV_STATUS_EN
    bad = bad || (period_cnt !== x.pc);
`endif
    if (bad) begin
      failures++;
`ifdef CLKDIV_STATUS_EN
      $display("FAIL vec%0d clk/tick/busy/ack/pc got %b%b%b%b/%0d want %b%b%b%b/%0d",
               x.idx, clk_out, tick, busy, load_ack, period_cnt,
               x.c, x.t, x.b, x.a, x.pc);
`else
      $display("FAIL vec%0d clk/tick/busy/ack got %b%b%b%b want %b%b%b%b",
               x.idx, clk_out, tick, busy, load_ack,
               x.c, x.t, x.b, x.a);
`endif
    end
  endtask

  initial begin
    bit [15:0] pc_m;
    bit        prev_b;
    exp_t      x;

    // r e l ratio | clk tick busy ack  (outputs after the edge)
    add(1,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,0,0,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    // load 5 mid-period: this period stays 4
    add(0,1,1,5, 0,0,1,1);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    // loads 0 then 1 clamp to 2
    add(0,1,1,0, 1,0,1,1);
    add(0,1,1,1, 1,0,1,1);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 0,0,1,0);
    // load 6 on the wrap edge: applies one boundary later
    add(0,1,1,6, 1,1,1,1);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    // drop en at cnt=1 of N=6: period completes
    add(0,0,0,0, 1,0,1,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    // loads 7 then 3 in one period: 3 wins
    add(0,1,1,7, 1,0,1,1);
    add(0,1,1,3, 0,0,1,1);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    // switch to 5, then reset at cnt=2
    add(0,1,1,5, 1,0,1,1);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(1,1,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    // pending 7 discarded by reset: ratio stays 4
    add(0,1,1,7, 1,0,1,1);
    add(1,1,0,0, 0,0,0,0);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);
    // stop, then load 3 while idle: used on next start
    add(0,0,0,0, 1,0,1,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,0,1,3, 0,0,0,1);
    add(0,1,0,0, 1,1,1,0);
    add(0,1,0,0, 1,0,1,0);
    add(0,1,0,0, 0,0,1,0);
    add(0,1,0,0, 1,1,1,0);

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_ratio = '0;
    pc_m = '0;
    prev_b = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_in);
      if (sb.size() > 0) check_one();
      rst       = vecs[i].r;
      en        = vecs[i].e;
      div_load  = vecs[i].l;
      div_ratio = vecs[i].d;
      // A wrap is a RUN edge ending in a new tick or a return to idle.
      if (vecs[i].r) pc_m = '0;
      else if (prev_b && (vecs[i].t || !vecs[i].b) && pc_m != 16'hFFFF)
        pc_m = pc_m + 16'd1;
      prev_b = vecs[i].b;
      x.idx = i;
      x.c = vecs[i].c; x.t = vecs[i].t;
      x.b = vecs[i].b; x.a = vecs[i].a;
      x.pc = pc_m;
      sb.push_back(x);
    end
    @(negedge clk_in);
    if (sb.size() > 0) check_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
